// File: rtl/synth_key_pkg.sv
// Shared types for the key-to-note controller: event polarity, FSM states and
// stack operation codes.
package synth_key_pkg;

  localparam logic EVT_OFF = 1'b0;
  localparam logic EVT_ON  = 1'b1;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_e;

  typedef enum logic {
    OP_PUSH   = 1'b0,
    OP_REMOVE = 1'b1
  } op_e;

endpackage

// File: rtl/key_note_ctrl_note_stack.sv
// Last-note-priority stack of held keys. Slot 0 is the oldest entry; removal
// compacts the entries above it in a single cycle. Outputs show the post-op view.
module note_stack
  import synth_key_pkg::*;
#(
  parameter int NUM_KEYS = 8,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid_i,
  input  op_e              op_i,
  input  logic [IDX_W-1:0] op_idx_i,
  output logic [IDX_W-1:0] top_o,
  output logic [IDX_W:0]   count_o,
  output logic             hit_o,
  output logic             rm_top_o
);

  localparam int CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] stk_q [NUM_KEYS];
  logic [IDX_W-1:0] stk_d [NUM_KEYS];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_s;
  logic [IDX_W-1:0] cur_top_s, nxt_top_s;

  // Top of the stack before the operation.
  always_comb begin
    cur_top_s = '0;
    for (int j = 0; j < NUM_KEYS; j++) begin
      cur_top_s = (CNT_W'(j + 1) == cnt_q) ? stk_q[j] : cur_top_s;
    end
  end

  // Push at the count slot, or find-and-compact for a removal.
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    hit_s = 1'b0;
    if (op_valid_i && (op_i == OP_PUSH)) begin
      for (int j = 0; j < NUM_KEYS; j++) begin
        stk_d[j] = (CNT_W'(j) == cnt_q) ? op_idx_i : stk_q[j];
      end
      cnt_d = (cnt_q < CNT_W'(NUM_KEYS)) ? cnt_q + CNT_W'(1) : cnt_q;
    end else if (op_valid_i && (op_i == OP_REMOVE)) begin
      for (int j = 0; j < NUM_KEYS - 1; j++) begin
        hit_s    = hit_s | ((CNT_W'(j) < cnt_q) && (stk_q[j] == op_idx_i));
        stk_d[j] = hit_s ? stk_q[j+1] : stk_q[j];
      end
      hit_s = hit_s | ((CNT_W'(NUM_KEYS - 1) < cnt_q) && (stk_q[NUM_KEYS-1] == op_idx_i));
      stk_d[NUM_KEYS-1] = hit_s ? '0 : stk_q[NUM_KEYS-1];
      cnt_d = hit_s ? cnt_q - CNT_W'(1) : cnt_q;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Top of the stack after the operation.
  always_comb begin
    nxt_top_s = '0;
    for (int j = 0; j < NUM_KEYS; j++) begin
      nxt_top_s = (CNT_W'(j + 1) == cnt_d) ? stk_d[j] : nxt_top_s;
    end
  end

  // Stack storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int j = 0; j < NUM_KEYS; j++) begin
        stk_q[j] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      stk_q <= stk_d;
    end
  end

  assign top_o    = nxt_top_s;
  assign count_o  = cnt_d;
  assign hit_o    = hit_s;
  assign rm_top_o = hit_s && (cur_top_s == op_idx_i);

endmodule

// File: rtl/key_note_ctrl.sv
// Monophonic key controller: captures key edges, keeps a last-note-priority
// stack, drives gate/note and emits NOTE_ON/NOTE_OFF events on a handshake.
module key_note_ctrl
  import synth_key_pkg::*;
#(
  parameter  int NUM_KEYS = 8,
  localparam int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic                gate,
  output logic [IDX_W-1:0]    note,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                evt_on,
  output logic [IDX_W-1:0]    evt_note
);

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      lowest_idx = v[i] ? IDX_W'(i) : lowest_idx;
    end
  endfunction

  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] key_q, press_q, press_d, rel_q, rel_d;
  logic [NUM_KEYS-1:0] rise_s, fall_s, clr_press_s, clr_rel_s, press_eff_s, rel_eff_s;
  logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
  logic                sel_rel_q, sel_rel_d;
  logic                gate_q, gate_d, evt_valid_q, evt_valid_d, evt_on_q, evt_on_d;
  logic [IDX_W-1:0]    note_q, note_d, evt_note_q, evt_note_d;
  logic                op_valid_s, evt_gen_s, st_hit_s, st_rm_top_s;
  logic [IDX_W-1:0]    st_top_s;
  logic [IDX_W:0]      st_count_s;

  // A rise and a fall on the same key cancel while either is still pending.
  assign rise_s      = key_in & ~key_q;
  assign fall_s      = ~key_in & key_q;
  assign press_eff_s = press_q & ~clr_press_s;
  assign rel_eff_s   = rel_q & ~clr_rel_s;
  assign press_d     = (press_eff_s & ~fall_s) | (rise_s & ~rel_eff_s);
  assign rel_d       = (rel_eff_s & ~rise_s) | (fall_s & ~press_eff_s);
  assign evt_gen_s   = !sel_rel_q || st_rm_top_s;

  note_stack #(.NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) u_stack (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid_i (op_valid_s),
    .op_i       (sel_rel_q ? OP_REMOVE : OP_PUSH),
    .op_idx_i   (sel_idx_q),
    .top_o      (st_top_s),
    .count_o    (st_count_s),
    .hit_o      (st_hit_s),
    .rm_top_o   (st_rm_top_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a non-top release produces no event and skips EMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    state_d = ((|rel_q) || (|press_q)) ? UPDATE : SCAN;
      UPDATE:  state_d = evt_gen_s ? EMIT : SCAN;
      EMIT:    state_d = evt_ready ? SCAN : EMIT;
      default: state_d = SCAN;
    endcase
  end

  // Selection, stack op and next values of the registered outputs.
  always_comb begin
    sel_idx_d   = sel_idx_q;
    sel_rel_d   = sel_rel_q;
    clr_press_s = '0;
    clr_rel_s   = '0;
    op_valid_s  = 1'b0;
    gate_d      = gate_q;
    note_d      = note_q;
    evt_valid_d = evt_valid_q;
    evt_on_d    = evt_on_q;
    evt_note_d  = evt_note_q;
    case (state_q)
      SCAN: begin
        if (|rel_q) begin
          sel_idx_d = lowest_idx(rel_q);
          sel_rel_d = 1'b1;
          clr_rel_s = rel_q & (~rel_q + NUM_KEYS'(1));
        end else if (|press_q) begin
          sel_idx_d   = lowest_idx(press_q);
          sel_rel_d   = 1'b0;
          clr_press_s = press_q & (~press_q + NUM_KEYS'(1));
        end else begin
          sel_idx_d = sel_idx_q;
        end
      end
      UPDATE: begin
        op_valid_s  = 1'b1;
        gate_d      = (st_count_s != '0);
        note_d      = (st_count_s != '0) ? st_top_s : note_q;
        evt_valid_d = evt_gen_s;
        evt_on_d    = !evt_gen_s ? evt_on_q :
                      (sel_rel_q && (st_count_s == '0)) ? EVT_OFF : EVT_ON;
        evt_note_d  = !evt_gen_s ? evt_note_q :
                      (sel_rel_q && (st_count_s != '0)) ? st_top_s : sel_idx_q;
      end
      EMIT:    evt_valid_d = !evt_ready;
      default: evt_valid_d = 1'b0;
    endcase
  end

  // Edge capture, pending masks, selection and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      press_q     <= '0;
      rel_q       <= '0;
      sel_idx_q   <= '0;
      sel_rel_q   <= 1'b0;
      gate_q      <= 1'b0;
      note_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_on_q    <= EVT_OFF;
      evt_note_q  <= '0;
    end else begin
      key_q       <= key_in;
      press_q     <= press_d;
      rel_q       <= rel_d;
      sel_idx_q   <= sel_idx_d;
      sel_rel_q   <= sel_rel_d;
      gate_q      <= gate_d;
      note_q      <= note_d;
      evt_valid_q <= evt_valid_d;
      evt_on_q    <= evt_on_d;
      evt_note_q  <= evt_note_d;
    end
  end

  assign gate      = gate_q;
  assign note      = note_q;
  assign evt_valid = evt_valid_q;
  assign evt_on    = evt_on_q;
  assign evt_note  = evt_note_q;

endmodule

// File: tb/tb_key_note_ctrl.sv
// Bench for key_note_ctrl: directed scenarios plus random key changes, checked
// against a queue-based last-note-priority model and an expected-event queue.
module tb_key_note_ctrl;

  localparam int NK = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_in = '0;
  logic          gate, evt_valid, evt_on;
  logic          evt_ready = 1'b1;
  logic [IW-1:0] note, evt_note;

  key_note_ctrl #(.NUM_KEYS(NK)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .gate(gate), .note(note),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_on(evt_on), .evt_note(evt_note)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_pass = 0, n_fail = 0;
  int            m_stk[$];
  int            exp_q[$];
  int            m_note = 0;
  logic [NK-1:0] m_keys = '0;
  int            rdy_mode = 0;
  logic          stall = 1'b0;
  logic          s_on;
  logic [IW-1:0] s_note;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input int on, input int idx);
    return on * (1 << IW) + idx;
  endfunction

  task automatic m_press(input int i);
    m_stk.push_back(i);
    m_note = i;
    exp_q.push_back(enc(1, i));
  endtask

  task automatic m_release(input int i);
    int p = -1;
    for (int j = 0; j < m_stk.size(); j++) if (m_stk[j] == i) p = j;
    if (p >= 0) begin
      if (p == m_stk.size() - 1) begin
        m_stk.delete(p);
        if (m_stk.size() != 0) begin
          m_note = m_stk[m_stk.size() - 1];
          exp_q.push_back(enc(1, m_note));
        end else begin
          exp_q.push_back(enc(0, i));
        end
      end else begin
        m_stk.delete(p);
      end
    end
  endtask

  // Releases are served before presses, each in ascending key order.
  task automatic apply(input logic [NK-1:0] nk);
    for (int i = 0; i < NK; i++) if (m_keys[i] && !nk[i]) m_release(i);
    for (int i = 0; i < NK; i++) if (!m_keys[i] && nk[i]) m_press(i);
    m_keys = nk;
    key_in = nk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       evt_ready = 1'b1;
      1:       evt_ready = 1'($urandom_range(0, 1));
      default: evt_ready = 1'b0;
    endcase
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (24) step();
    chk({tag, "_gate"}, 32'(gate), 32'(m_stk.size() != 0));
    chk({tag, "_note"}, 32'(note), 32'(m_note));
    chk({tag, "_idle"}, 32'(evt_valid), 32'd0);
  endtask

  // Event monitor: checks every accepted event and stability while stalled.
  always @(negedge clk) begin
    int e;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(evt_valid), 32'd1);
        chk("hold_on", 32'(evt_on), 32'(s_on));
        chk("hold_note", 32'(evt_note), 32'(s_note));
      end
      if (evt_valid && evt_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk("event", 32'({evt_on, evt_note}), 32'(e));
      end
      stall  = evt_valid && !evt_ready;
      s_on   = evt_on;
      s_note = evt_note;
    end
  end

  initial begin
    logic [NK-1:0] nk;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gate", 32'(gate), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_on", 32'(evt_on), 32'd0);
    chk("rst_enote", 32'(evt_note), 32'd0);
    rst_n = 1'b1;
    step();

    // Single press: latency to gate/note and the event pulse
    apply(8'h08);
    step();
    chk("t1_k_valid", 32'(evt_valid), 32'd0);
    step();
    chk("t1_k1_gate", 32'(gate), 32'd0);
    step();
    chk("t1_k2_gate", 32'(gate), 32'd1);
    chk("t1_k2_note", 32'(note), 32'd3);
    chk("t1_k2_valid", 32'(evt_valid), 32'd1);
    chk("t1_k2_on", 32'(evt_on), 32'd1);
    chk("t1_k2_enote", 32'(evt_note), 32'd3);
    step();
    chk("t1_k3_valid", 32'(evt_valid), 32'd0);
    settle("t1");

    // Fallback to the held note
    apply(8'h28); settle("t2a");
    apply(8'h08); settle("t2b");
    apply(8'h00); settle("t2c");

    // Non-top release, fallback, final off
    apply(8'h04); settle("t3a");
    apply(8'h14); settle("t3b");
    apply(8'h54); settle("t3c");
    apply(8'h44); settle("t3d");
    apply(8'h04); settle("t3e");
    apply(8'h00); settle("t3f");

    // Simultaneous presses
    apply(8'h82); settle("t4a");
    apply(8'h00); settle("t4b");

    // Consumer stall: event held, nothing lost
    rdy_mode = 2;
    step();
    apply(8'h01);
    repeat (5) step();
    apply(8'h11);
    repeat (20) step();
    chk("t5_valid", 32'(evt_valid), 32'd1);
    chk("t5_on", 32'(evt_on), 32'd1);
    chk("t5_enote", 32'(evt_note), 32'd0);
    rdy_mode = 0;
    settle("t5a");
    apply(8'h00); settle("t5b");

    // Reset during EMIT with a key held through it
    rdy_mode = 2;
    step();
    apply(8'h20);
    repeat (4) step();
    chk("t6_pre_valid", 32'(evt_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(evt_valid), 32'd0);
    chk("t6_rst_gate", 32'(gate), 32'd0);
    chk("t6_rst_note", 32'(note), 32'd0);
    exp_q.delete();
    m_stk.delete();
    m_note = 0;
    m_keys = '0;
    step();
    step();
    rst_n = 1'b1;
    rdy_mode = 0;
    apply(8'h20); settle("t6a");
    apply(8'h00); settle("t6b");

    // Random key changes with a randomly stalling consumer
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      nk = key_in;
      repeat ($urandom_range(1, 3)) begin
        int b = $urandom_range(0, NK - 1);
        nk[b] = ~nk[b];
      end
      apply(nk);
      settle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
